seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned integer divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_restoring_divider.sv | 122 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock using a single WIDTH+1-bit subtractor.
// Latency: WIDTH busy cycles after the accepting edge, then a one-cycle done; divide-by-zero goes straight to done.
// Backpressure: start is honoured only in IDLE; requests while busy/done are dropped, results hold until the next op completes.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    // A restored partial remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted value needs the extra bit only for the subtraction.
    always_comb begin
        r_shift = {r_reg, q_reg[WIDTH-1]};
        diff    = r_shift + ~{1'b0, d_reg} + {{WIDTH{1'b0}}, 1'b1};
        fits    = ~diff[WIDTH];
        q_next  = {q_reg[WIDTH-2:0], fits};
        r_next  = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        count <= CW'(WIDTH);
                        q_reg <= dividend;
                        r_reg <= '0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count - 1'b1;
                    // Published results change only on the final iteration, i.e. entering FIN.
                    if (count == CW'(1)) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised self-checking bench for seq_restoring_divider against a plain x/y, x%y model.
module tb_seq_restoring_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Issue one division, hold start until accepted, then verify latency and results.
    // gap==0 leaves the bench in the FIN cycle so the next call exercises a back-to-back start.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int gap, input bit intrude);
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        int           exp_lat;
        int           cnt;
        int           bcnt;
        int           acc;
        exp_q   = (y == 0) ? {W{1'b1}} : W'(x / y);
        exp_r   = (y == 0) ? x : W'(x % y);
        exp_lat = (y == 0) ? 0 : W;

        dividend = x;
        divisor  = y;
        start    = 1'b1;
        acc      = 0;
        do begin
            @(posedge clk);
            #1;
            acc++;
        end while (!(busy || done) && acc < 10);
        check("accept", 32'(busy || done), 32'd1);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);

        cnt  = 0;
        bcnt = 0;
        while (!done && cnt < 100) begin
            if (busy) bcnt++;
            if (intrude && cnt == 5) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd4;
            end else if (intrude && cnt == 6) begin
                start    = 1'b0;
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(exp_lat));
        check("busy_cycles", 32'(bcnt), 32'(exp_lat));
        check("busy_done_excl", 32'(busy & done), 32'd0);
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_zero", 32'(div_zero), 32'(y == 0));

        if (gap > 0) begin
            @(posedge clk);
            #1;
            check("done_pulse", 32'(done), 32'd0);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            check("idle_busy", 32'(busy), 32'd0);
            check("hold_q", 32'(quotient), 32'(exp_q));
            check("hold_r", 32'(remainder), 32'(exp_r));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(16'd100, 16'd7, 2, 1'b0);
        run_op(16'hFFFF, 16'd1, 2, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 2, 1'b0);
        run_op(16'd3, 16'd10, 2, 1'b0);
        run_op(16'd0, 16'd5, 2, 1'b0);
        run_op(16'd5, 16'd0, 2, 1'b0);
        run_op(16'd1000, 16'd3, 3, 1'b1);

        // Asynchronous reset mid-division: outputs clear without a clock edge, no done follows.
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_div_zero", 32'(div_zero), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) check("arst_no_done", 32'(done || busy), 32'd0);
        end
        check("arst_quiet", 32'(done || busy), 32'd0);
        run_op(16'd50, 16'd6, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            int           sel;
            x   = W'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      y = '0;
            else if (sel < 4)  y = W'($urandom_range(1, 15));
            else if (sel == 4) y = x;
            else               y = W'($urandom);
            run_op(x, y, (i % 3 == 0) ? 0 : int'($urandom_range(1, 3)), 1'b0);
        end
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
